// File: rtl/div_unit.sv
// Sequential signed divider for the multicycle MIPS datapath: one restoring
// step per cycle on operand magnitudes, signs reapplied on completion.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             div_init,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_stop,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] rem_reg, quo_reg, b_mag_reg;
    logic             sign_q_reg, sign_r_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg;
    logic             stop_reg, zero_reg;
    logic             stop_next, zero_next;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rem_sh, trial;
    logic             trial_neg, start_ok;

    // Magnitudes are unsigned, so -2^31 maps cleanly onto 2^31.
    assign a_mag     = a[WIDTH-1] ? -a : a;
    assign b_mag     = b[WIDTH-1] ? -b : b;
    assign start_ok  = div_init && (b != '0);
    assign rem_sh    = {rem_reg, quo_reg[WIDTH-1]};
    assign trial     = rem_sh - {1'b0, b_mag_reg};
    assign trial_neg = trial[WIDTH];

    always_ff @(posedge clk) begin
        if (reset_in) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_ok) state_next = RUN;
            RUN:     if (cnt_reg == CW'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stop_next = 1'b0;
        zero_next = 1'b0;
        case (state_reg)
            IDLE:    zero_next = div_init && (b == '0);
            DONE:    stop_next = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            cnt_reg    <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            b_mag_reg  <= '0;
            sign_q_reg <= 1'b0;
            sign_r_reg <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            stop_reg   <= 1'b0;
            zero_reg   <= 1'b0;
        end else begin
            stop_reg <= stop_next;
            zero_reg <= zero_next;
            case (state_reg)
                IDLE: begin
                    if (start_ok) begin
                        quo_reg    <= a_mag;
                        b_mag_reg  <= b_mag;
                        sign_q_reg <= a[WIDTH-1] ^ b[WIDTH-1];
                        sign_r_reg <= a[WIDTH-1];
                        rem_reg    <= '0;
                        cnt_reg    <= CW'(WIDTH);
                    end
                end
                RUN: begin
                    // quo_reg doubles as the dividend shifter; its freed LSBs collect quotient bits.
                    rem_reg <= trial_neg ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
                    quo_reg <= {quo_reg[WIDTH-2:0], ~trial_neg};
                    cnt_reg <= cnt_reg - CW'(1);
                end
                DONE: begin
                    lo_reg <= sign_q_reg ? -quo_reg : quo_reg;
                    hi_reg <= sign_r_reg ? -rem_reg : rem_reg;
                end
                default: ;
            endcase
        end
    end

    assign hi       = hi_reg;
    assign lo       = lo_reg;
    assign div_stop = stop_reg;
    assign div_zero = zero_reg;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table of signed divisions plus
// hand-written sequences for zero divisor, ignored start, abort and back-to-back.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        reset_in;
    logic        div_init;
    logic [31:0] a, b;
    logic [31:0] hi, lo;
    logic        div_stop, div_zero;

    div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset_in (reset_in),
        .div_init (div_init),
        .a        (a),
        .b        (b),
        .hi       (hi),
        .lo       (lo),
        .div_stop (div_stop),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic both_hi = 1'b0;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (div_stop && div_zero) both_hi = 1'b1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Starts a division at the next edge and waits (bounded) for div_stop.
    task automatic run_div(input logic [31:0] av, input logic [31:0] bv,
                           output int lat, output logic [31:0] rlo, output logic [31:0] rhi);
        @(negedge clk);
        div_init = 1'b1; a = av; b = bv;
        @(posedge clk);
        @(negedge clk);
        div_init = 1'b0; a = $urandom; b = $urandom;
        lat = 0;
        while (!div_stop && lat < 100) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
        rlo = lo; rhi = hi;
    endtask

    task automatic watch_no_stop(input int ncyc, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (div_stop) seen = 1'b1;
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] rlo, rhi;
        logic        seen;
        int          pulse_cyc[3];
        logic [31:0] pulse_lo[3], pulse_hi[3];
        int          npulse;

        vecs[0]  = '{32'd100,       32'd7,          32'd14,         32'd2};
        vecs[1]  = '{-32'sd100,     32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE};
        vecs[2]  = '{32'd100,       -32'sd7,        32'hFFFF_FFF2,  32'd2};
        vecs[3]  = '{-32'sd100,     -32'sd7,        32'd14,         32'hFFFF_FFFE};
        vecs[4]  = '{32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
        vecs[5]  = '{32'd7,         32'd100,        32'd0,          32'd7};
        vecs[6]  = '{32'h7FFF_FFFF, 32'd1,          32'h7FFF_FFFF,  32'd0};
        vecs[7]  = '{32'h8000_0000, 32'd2,          32'hC000_0000,  32'd0};
        vecs[8]  = '{32'hFFFF_FFFF, 32'h8000_0000,  32'd0,          32'hFFFF_FFFF};
        vecs[9]  = '{32'h8000_0000, 32'h8000_0000,  32'd1,          32'd0};
        vecs[10] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF,  32'd0,          32'hFFFF_FFFF};
        vecs[11] = '{32'd1000000,   -32'sd3,        32'hFFFA_E9EB,  32'd1};

        reset_in = 1'b1; div_init = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_in = 1'b0;
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_stop", {31'd0, div_stop}, 32'd0);
        check("reset_zero", {31'd0, div_zero}, 32'd0);
        $display("reset: hi=%h lo=%h stop=%b zero=%b", hi, lo, div_stop, div_zero);

        for (int i = 0; i < 12; i++) begin
            run_div(vecs[i].a, vecs[i].b, lat, rlo, rhi);
            $display("div %h / %h: lo=%h hi=%h latency=%0d", vecs[i].a, vecs[i].b, rlo, rhi, lat);
            check($sformatf("vec%0d_latency", i), lat, 33);
            check($sformatf("vec%0d_lo", i), rlo, vecs[i].lo);
            check($sformatf("vec%0d_hi", i), rhi, vecs[i].hi);
            @(negedge clk);
            check($sformatf("vec%0d_stop_fall", i), {31'd0, div_stop}, 32'd0);
        end

        // Zero divisor after a completed 100/7.
        run_div(32'd100, 32'd7, lat, rlo, rhi);
        @(negedge clk);
        div_init = 1'b1; a = 32'd5; b = 32'd0;
        @(posedge clk);
        @(negedge clk);
        div_init = 1'b0;
        check("zero_pulse", {31'd0, div_zero}, 32'd1);
        check("zero_no_stop", {31'd0, div_stop}, 32'd0);
        @(negedge clk);
        check("zero_fall", {31'd0, div_zero}, 32'd0);
        watch_no_stop(40, seen);
        check("zero_stop_seen", {31'd0, seen}, 32'd0);
        check("zero_hi_kept", hi, 32'd2);
        check("zero_lo_kept", lo, 32'd14);
        $display("zero divisor: hi=%h lo=%h stop_seen=%b", hi, lo, seen);

        // Restart request with new operands during RUN is ignored.
        @(negedge clk);
        div_init = 1'b1; a = 32'd100; b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        div_init = 1'b0;
        lat = 0;
        while (!div_stop && lat < 100) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (lat == 5) begin div_init = 1'b1; a = 32'd9; b = 32'd2; end
            else div_init = 1'b0;
        end
        div_init = 1'b0;
        check("ignore_latency", lat, 33);
        check("ignore_lo", lo, 32'd14);
        check("ignore_hi", hi, 32'd2);
        $display("ignored start: lo=%h hi=%h latency=%0d", lo, hi, lat);
        @(negedge clk);

        // Reset mid-RUN, with a simultaneous div_init that must lose.
        @(negedge clk);
        div_init = 1'b1; a = 32'd100; b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        div_init = 1'b0;
        repeat (10) @(negedge clk);
        reset_in = 1'b1; div_init = 1'b1;
        @(negedge clk);
        reset_in = 1'b0; div_init = 1'b0;
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_stop", {31'd0, div_stop}, 32'd0);
        watch_no_stop(40, seen);
        check("abort_stop_seen", {31'd0, seen}, 32'd0);
        $display("abort: hi=%h lo=%h stop_seen=%b", hi, lo, seen);

        // div_init held high: back-to-back 9/2.
        @(negedge clk);
        div_init = 1'b1; a = 32'd9; b = 32'd2;
        npulse = 0;
        for (int i = 0; i < 150 && npulse < 3; i++) begin
            @(negedge clk);
            if (div_stop) begin
                pulse_cyc[npulse] = cyc;
                pulse_lo[npulse]  = lo;
                pulse_hi[npulse]  = hi;
                npulse++;
            end
        end
        div_init = 1'b0;
        check("b2b_pulses", npulse, 3);
        for (int i = 0; i < npulse; i++) begin
            $display("back-to-back pulse %0d: cycle=%0d lo=%h hi=%h", i, pulse_cyc[i], pulse_lo[i], pulse_hi[i]);
            check($sformatf("b2b%0d_lo", i), pulse_lo[i], 32'd4);
            check($sformatf("b2b%0d_hi", i), pulse_hi[i], 32'd1);
            if (i > 0) check($sformatf("b2b%0d_gap", i), pulse_cyc[i] - pulse_cyc[i-1], 34);
        end

        check("stop_zero_overlap", {31'd0, both_hi}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
